// File: rtl/ex_flag_stage_if.sv
// Execute-stage back-end bundle: AU operation, pipeline controls and branch query in; EX/MEM result, flags and branch answer out.
// The slave modport faces the flag stage; the master modport faces whoever drives the AU side.
interface ex_flag_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [3:0]       cmd;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             stall;
    logic             flush;
    logic             br_req;
    logic [2:0]       br_cond;

    logic             out_valid;
    logic [WIDTH-1:0] ex_result;
    logic [2:0]       flags;
    logic             br_done;
    logic             br_taken;

    modport slave (
        input  in_valid, cmd, a, b, result, stall, flush, br_req, br_cond,
        output out_valid, ex_result, flags, br_done, br_taken
    );

    modport master (
        output in_valid, cmd, a, b, result, stall, flush, br_req, br_cond,
        input  out_valid, ex_result, flags, br_done, br_taken
    );
endinterface

// File: rtl/ex_flag_stage.sv
// EX/MEM result register plus {Z,V,N} flag register and branch-condition evaluation; 1-cycle latency.
// stall freezes every register (branch answer forced idle); flush drops the captured op and its flag update.
module ex_flag_stage #(
    parameter int         WIDTH     = 16,
    parameter logic [2:0] RST_FLAGS = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_flag_stage_if.slave       bus
);
    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_PADD = 4'b1000;

    localparam int ZF = 2;
    localparam int VF = 1;
    localparam int NF = 0;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] ex_result_q, ex_result_d;
    logic [2:0]       flags_q,     flags_d;
    logic             br_done_q,   br_done_d;
    logic             br_taken_q,  br_taken_d;

    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             v_raw;
    logic             is_addsub;
    logic             is_padd;
    logic             res_zero;
    logic             cond_true;
    logic             capture;

    // Overflow is rebuilt from the raw operands because the AU only hands over the saturated value.
    always_comb begin
        sub       = bus.cmd[1];
        bx        = sub ? ~bus.b : bus.b;
        sum       = bus.a + bx + WIDTH'(sub);
        v_raw     = (bus.a[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != bus.a[WIDTH-1]);
        is_addsub = (bus.cmd == CMD_ADD) | (bus.cmd == CMD_SUB);
        is_padd   = (bus.cmd == CMD_PADD);
        res_zero  = (bus.result == '0);
    end

    always_comb begin
        cond_true = 1'b0;
        case (bus.br_cond)
            3'b000:  cond_true = ~flags_q[ZF];
            3'b001:  cond_true =  flags_q[ZF];
            3'b010:  cond_true = ~flags_q[ZF] & ~flags_q[NF];
            3'b011:  cond_true =  flags_q[NF];
            3'b100:  cond_true =  flags_q[ZF] | ~flags_q[NF];
            3'b101:  cond_true =  flags_q[ZF] |  flags_q[NF];
            3'b110:  cond_true =  flags_q[VF];
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        ex_result_d = ex_result_q;
        flags_d     = flags_q;
        br_done_d   = 1'b0;
        br_taken_d  = 1'b0;
        capture     = bus.in_valid & ~bus.flush;

        if (!bus.stall) begin
            out_valid_d = capture;
            br_done_d   = bus.br_req;
            // Branch sees flags_q, i.e. the value before this edge's update.
            br_taken_d  = bus.br_req & cond_true;
            if (capture) begin
                ex_result_d = bus.result;
                if (is_addsub) begin
                    flags_d[ZF] = res_zero;
                    flags_d[VF] = v_raw;
                    flags_d[NF] = bus.result[WIDTH-1];
                end else if (!is_padd) begin
                    flags_d[ZF] = res_zero;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ex_result_q <= '0;
            flags_q     <= RST_FLAGS;
            br_done_q   <= 1'b0;
            br_taken_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ex_result_q <= ex_result_d;
            flags_q     <= flags_d;
            br_done_q   <= br_done_d;
            br_taken_q  <= br_taken_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ex_result = ex_result_q;
    assign bus.flags     = flags_q;
    assign bus.br_done   = br_done_q;
    assign bus.br_taken  = br_taken_q;
endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed vector table for the execute-stage flag register, followed by a stall/branch hand sequence.
module tb_ex_flag_stage;
    logic clk;
    logic rst;

    ex_flag_stage_if #(.WIDTH(16)) bus ();

    ex_flag_stage #(.WIDTH(16), .RST_FLAGS(3'b000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        stall;
        logic        flush;
        logic        brq;
        logic [2:0]  cond;
        logic        ov;
        logic [15:0] xr;
        logic [2:0]  fl;
        logic        bd;
        logic        bt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_err;

    task automatic add_vec(input logic r, input logic iv, input logic [3:0] cmd,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                           input logic st, input logic fl_in, input logic brq, input logic [2:0] cond,
                           input logic ov, input logic [15:0] xr, input logic [2:0] fl,
                           input logic bd, input logic bt);
        vec_t v;
        v.rst = r;   v.iv = iv;   v.cmd = cmd; v.a = a; v.b = b; v.res = res;
        v.stall = st; v.flush = fl_in; v.brq = brq; v.cond = cond;
        v.ov = ov;   v.xr = xr;   v.fl = fl;   v.bd = bd; v.bt = bt;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst         = v.rst;
        bus.in_valid = v.iv;
        bus.cmd     = v.cmd;
        bus.a       = v.a;
        bus.b       = v.b;
        bus.result  = v.res;
        bus.stall   = v.stall;
        bus.flush   = v.flush;
        bus.br_req  = v.brq;
        bus.br_cond = v.cond;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [15:0] xr,
                           input logic [2:0] fl, input logic bd, input logic bt);
        chk({tag, " out_valid"}, 16'(bus.out_valid), 16'(ov));
        chk({tag, " ex_result"}, bus.ex_result, xr);
        chk({tag, " flags"},     16'(bus.flags), 16'(fl));
        chk({tag, " br_done"},   16'(bus.br_done), 16'(bd));
        chk({tag, " br_taken"},  16'(bus.br_taken), 16'(bt));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t h;
        n_cmp = 0;
        n_err = 0;

        //       rst iv cmd    a        b        res      st fl brq cond | ov xr       flags   bd bt
        // reset with inputs toggling; an op in flight is lost
        add_vec(1, 1, 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 0, 1, 3'd7, 0, 16'h0000, 3'b000, 0, 0);
        add_vec(1, 1, 4'h2, 16'h1234, 16'h5678, 16'hAAAA, 1, 1, 1, 3'd1, 0, 16'h0000, 3'b000, 0, 0);
        // positive overflow, saturated result
        add_vec(0, 1, 4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 0, 0, 3'd0, 1, 16'h7FFF, 3'b010, 0, 0);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3'd6, 0, 16'h7FFF, 3'b010, 1, 1);
        // SUB to zero, then EQ / NE
        add_vec(0, 1, 4'h2, 16'h1234, 16'h1234, 16'h0000, 0, 0, 0, 3'd0, 1, 16'h0000, 3'b100, 0, 0);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3'd1, 0, 16'h0000, 3'b100, 1, 1);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3'd0, 0, 16'h0000, 3'b100, 1, 0);
        // same-cycle ADD + EQ sees old Z
        add_vec(0, 1, 4'h0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 0, 0, 1, 3'd1, 1, 16'hFFFE, 3'b001, 1, 1);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3'd3, 0, 16'hFFFE, 3'b001, 1, 1);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3'd2, 0, 16'hFFFE, 3'b001, 1, 0);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3'd4, 0, 16'hFFFE, 3'b001, 1, 0);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3'd5, 0, 16'hFFFE, 3'b001, 1, 1);
        // PADD leaves flags; NONARITH touches Z only
        add_vec(0, 1, 4'h8, 16'h7F7F, 16'h0101, 16'h7F7F, 0, 0, 0, 3'd0, 1, 16'h7F7F, 3'b001, 0, 0);
        add_vec(0, 1, 4'h5, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 3'd0, 1, 16'h0000, 3'b101, 0, 0);
        // negative overflow via SUB, then NONARITH keeps V and N
        add_vec(0, 1, 4'h2, 16'h8000, 16'h0001, 16'h8000, 0, 0, 0, 3'd0, 1, 16'h8000, 3'b011, 0, 0);
        add_vec(0, 1, 4'hF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 3'd0, 1, 16'h0000, 3'b111, 0, 0);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3'd6, 0, 16'h0000, 3'b111, 1, 1);
        add_vec(0, 1, 4'h1, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 3'd0, 1, 16'h1234, 3'b011, 0, 0);
        // stall for 3 cycles with ADD and br_req held
        add_vec(0, 1, 4'h0, 16'h0001, 16'h0001, 16'h0002, 1, 0, 1, 3'd7, 1, 16'h1234, 3'b011, 0, 0);
        add_vec(0, 1, 4'h0, 16'h0001, 16'h0001, 16'h0002, 1, 0, 1, 3'd7, 1, 16'h1234, 3'b011, 0, 0);
        add_vec(0, 1, 4'h0, 16'h0001, 16'h0001, 16'h0002, 1, 0, 1, 3'd7, 1, 16'h1234, 3'b011, 0, 0);
        // flush drops op and flag update, branch still answers
        add_vec(0, 1, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 3'd7, 0, 16'h1234, 3'b011, 1, 1);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 3'd7, 0, 16'h1234, 3'b011, 0, 0);
        add_vec(0, 1, 4'h0, 16'h4000, 16'h4000, 16'h7FFF, 0, 0, 0, 3'd0, 1, 16'h7FFF, 3'b010, 0, 0);
        add_vec(0, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 3'd0, 1, 16'h7FFF, 3'b010, 0, 0);
        add_vec(1, 0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 3'd0, 0, 16'h0000, 3'b000, 0, 0);

        h = vecs[0];
        drive(h);
        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].xr, vecs[i].fl, vecs[i].bd, vecs[i].bt);
        end

        // stalled ADD + NE request, then released: captured only once stall drops
        h = vecs[$];
        h.rst = 0; h.iv = 1; h.cmd = 4'h0; h.a = 16'h8000; h.b = 16'h8000; h.res = 16'h8000;
        h.stall = 1; h.flush = 0; h.brq = 1; h.cond = 3'd0;
        drive(h);
        step();
        chk_all("stall_hold", 0, 16'h0000, 3'b000, 0, 0);
        h.stall = 0;
        drive(h);
        step();
        chk_all("stall_release", 1, 16'h8000, 3'b011, 1, 1);
        h.stall = 1; h.iv = 0; h.brq = 0;
        drive(h);
        step();
        chk_all("stall_keep_valid", 1, 16'h8000, 3'b011, 0, 0);
        h.stall = 0; h.brq = 1; h.cond = 3'd3;
        drive(h);
        step();
        chk_all("post_stall_lt", 0, 16'h8000, 3'b011, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
